// File: rtl/computer_player.sv
// rtl/computer_player.sv - computer opponent: LFSR-driven move decisions paced by a tick divider
module computer_player #(
    parameter int               WIDTH  = 10,
    parameter int               PERIOD = 4,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter int               CW     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] threshold,
    output logic             move,
    output logic [WIDTH-1:0] random,
    output logic [CW-1:0]    move_count,
    output logic             busy
);

    localparam int DW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [DW-1:0]    r_div;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_nx;
    logic             r_move;
    logic [CW-1:0]    r_count;
    logic             w_tick;
    logic             w_hit;

    // Tick is judged on the current state, so a tick in the cycle RUN is left still completes.
    assign w_tick    = (r_state == S_RUN) && (r_div == DIV_LAST);
    assign w_hit     = mode ? (threshold != '0) : (threshold > r_lfsr);
    assign w_lfsr_nx = {r_lfsr[WIDTH-2:0], r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-4]};

    assign move       = r_move;
    assign random     = r_lfsr;
    assign move_count = r_count;
    assign busy       = (r_state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: freeze beats enable; only clear leaves FREEZE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (freeze) begin
                    w_state_nx = S_FREEZE;
                end else if (enable) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (freeze) begin
                    w_state_nx = S_FREEZE;
                end else if (!enable) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_FREEZE: begin
                if (clear) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Tick divider: counts only while staying in RUN, so every RUN entry starts at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (clear || (r_state != S_RUN) || (w_state_nx != S_RUN) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // LFSR: reseeds on clear or lock-up, otherwise advances only on a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else if (clear || (r_lfsr == '0)) begin
            r_lfsr <= SEED;
        end else if (w_tick) begin
            r_lfsr <= w_lfsr_nx;
        end
    end

    // Move pulse: one cycle after a tick whose decision used the pre-advance random value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_move <= 1'b0;
        end else begin
            r_move <= w_tick && w_hit;
        end
    end

    // Saturating move counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (r_move && (r_count != '1)) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_computer_player.sv
// tb/tb_computer_player.sv - self-checking bench for computer_player
module tb_computer_player;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       freeze;
    logic       clear;
    logic       mode;
    logic [9:0] threshold;
    logic       move;
    logic [9:0] random;
    logic [3:0] move_count;
    logic       busy;

    int         total;
    int         bad;
    logic [9:0] exp_rnd;
    int         exp_cnt;

    typedef struct {
        logic       mv;
        logic [9:0] rnd;
        logic       bz;
    } exp_t;

    exp_t sb[$];

    computer_player #(
        .WIDTH (10),
        .PERIOD(4),
        .SEED  (10'h001),
        .CW    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .freeze    (freeze),
        .clear     (clear),
        .mode      (mode),
        .threshold (threshold),
        .move      (move),
        .random    (random),
        .move_count(move_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] lfsr_nx(input logic [9:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    // Enter RUN from IDLE for n cycles, then drop enable; predictions go to the scoreboard first.
    task automatic run_phase(input int n, input logic [9:0] thr, input logic md, input string tag);
        logic [9:0] cur;
        logic       pend;
        exp_t       e;
        exp_t       got;
        cur  = exp_rnd;
        pend = 1'b0;
        for (int c = 0; c <= n; c++) begin
            e.rnd = cur;
            e.mv  = pend;
            e.bz  = (c < n);
            sb.push_back(e);
            pend = 1'b0;
            if ((c < n) && (c % 4 == 3)) begin
                pend = md ? (thr != 10'h000) : (thr > cur);
                if (pend && exp_cnt < 15) exp_cnt++;
                cur = lfsr_nx(cur);
            end
        end
        exp_rnd   = cur;
        mode      = md;
        threshold = thr;
        enable    = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s scoreboard empty at c=%0d", tag, c);
            end else begin
                got = sb.pop_front();
                if ({move, random, busy} !== {got.mv, got.rnd, got.bz}) begin
                    bad++;
                    $display("FAIL %s c=%0d move/random/busy got %b/%h/%b want %b/%h/%b",
                             tag, c, move, random, busy, got.mv, got.rnd, got.bz);
                end
            end
            if (c == n - 1) enable = 1'b0;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_rnd = 10'h001;
        exp_cnt = 0;
        total++;
        if ({random, move_count} !== {10'h001, 4'd0}) begin
            bad++;
            $display("FAIL clear random/count got %h/%0d want 001/0", random, move_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; freeze = 1'b0; clear = 1'b0; mode = 1'b0; threshold = 10'h000;
        repeat (3) @(negedge clk);
        total++;
        if ({random, move, move_count, busy} !== {10'h001, 1'b0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got r=%h m=%b c=%0d b=%b want r=001 m=0 c=0 b=0",
                     random, move, move_count, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_rnd = 10'h001;
        exp_cnt = 0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_hit_all();
        run_phase(12, 10'h3FF, 1'b0, "hit_all");
        @(negedge clk);
        total++;
        if (move_count !== 4'(exp_cnt) || exp_cnt != 3) begin
            bad++;
            $display("FAIL hit_all count got %0d want 3", move_count);
        end
    endtask

    task automatic test_zero_threshold();
        do_clear();
        run_phase(20, 10'h000, 1'b1, "zero_thr");
        @(negedge clk);
        total++;
        if (move_count !== 4'd0) begin
            bad++;
            $display("FAIL zero_thr count got %0d want 0", move_count);
        end
    endtask

    task automatic test_threshold3();
        do_clear();
        run_phase(12, 10'h003, 1'b0, "thr3");
        @(negedge clk);
        total++;
        if (move_count !== 4'd2) begin
            bad++;
            $display("FAIL thr3 count got %0d want 2", move_count);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        run_phase(80, 10'h001, 1'b1, "saturate");
        total++;
        if (move_count !== 4'd15) begin
            bad++;
            $display("FAIL saturate count got %0d want 15", move_count);
        end
        do_clear();
    endtask

    task automatic test_clear_with_move();
        do_clear();
        run_phase(4, 10'h3FF, 1'b1, "clr_move");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_rnd = 10'h001;
        exp_cnt = 0;
        total++;
        if (move_count !== 4'd0) begin
            bad++;
            $display("FAIL clear_with_move count got %0d want 0", move_count);
        end
    endtask

    task automatic test_freeze();
        do_clear();
        mode = 1'b1; threshold = 10'h001; enable = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL freeze_pre busy got %b want 1", busy);
        end
        freeze = 1'b1;
        @(negedge clk);
        freeze = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL freeze_enter busy got %b want 0", busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({busy, move, random} !== {1'b0, 1'b0, 10'h001}) begin
                bad++;
                $display("FAIL freeze_hold i=%0d b/m/r got %b/%b/%h want 0/0/001", i, busy, move, random);
            end
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL freeze_clear_idle busy got %b want 0", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL freeze_rerun busy got %b want 1", busy);
        end
        enable = 1'b0;
        @(negedge clk);
        exp_rnd = 10'h001;
        exp_cnt = 0;
    endtask

    task automatic test_reset_in_tick();
        do_clear();
        mode = 1'b0; threshold = 10'h3FF; enable = 1'b1;
        @(posedge clk);
        repeat (8) @(negedge clk);
        total++;
        if ({random, move_count} !== {10'h002, 4'd1}) begin
            bad++;
            $display("FAIL rst_tick_pre r/c got %h/%0d want 002/1", random, move_count);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({random, move_count, busy} !== {10'h001, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL rst_tick_async r/c/b got %h/%0d/%b want 001/0/0", random, move_count, busy);
        end
        @(negedge clk);
        total++;
        if ({move, random} !== {1'b0, 10'h001}) begin
            bad++;
            $display("FAIL rst_tick_drop m/r got %b/%h want 0/001", move, random);
        end
        enable = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        exp_rnd = 10'h001;
        exp_cnt = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hit_all();
        test_zero_threshold();
        test_threshold3();
        test_saturate();
        test_clear_with_move();
        test_freeze();
        test_reset_in_tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/computer_player.md
COMPUTER_PLAYER -- requirements
Module: computer_player

Interface
REQ-001 Parameter WIDTH, default 10, sets the width of the random value and the threshold.
REQ-002 Parameter PERIOD, default 4, sets the number of clk cycles per decision tick; legal range is 2 or greater.
REQ-003 Parameter SEED, default 10'h001 (WIDTH bits), is the LFSR reset value and SHALL be nonzero.
REQ-004 Parameter CW, default 4, sets the width of the move counter.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-007 enable  in  1  game active; high runs the decision engine.
REQ-008 freeze  in  1  game over; a one-cycle high latches FREEZE.
REQ-009 clear  in  1  synchronous: leaves FREEZE, zeroes move_count, reloads SEED.
REQ-010 mode  in  1  0 = random compare, 1 = deterministic (move on every tick).
REQ-011 threshold  in  WIDTH  difficulty, normally the switch setting.
REQ-012 move  out  1  one-cycle pulse; computer pulls the rope.
REQ-013 random  out  WIDTH  current LFSR state.
REQ-014 move_count  out  CW  saturating count of move pulses.
REQ-015 busy  out  1  high while state is RUN.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FREEZE.
REQ-017 IDLE SHALL go to RUN when enable=1.
REQ-018 RUN SHALL go to IDLE when enable=0.
REQ-019 IDLE or RUN SHALL go to FREEZE when freeze=1; freeze has priority over enable.
REQ-020 FREEZE SHALL go to IDLE only when clear=1; enable and freeze are ignored in FREEZE.
REQ-021 The divider div SHALL count 0..PERIOD-1 in RUN and wrap to 0; it SHALL be held at 0 in IDLE and FREEZE.
REQ-022 A tick SHALL occur in a cycle where state=RUN and div=PERIOD-1.
REQ-023 On a tick the LFSR SHALL advance: lfsr <= {lfsr[WIDTH-2:0], lfsr[WIDTH-1]^lfsr[WIDTH-4]}; the default taps are maximal-length for WIDTH=10.
REQ-024 The LFSR SHALL hold between ticks.
REQ-025 If the LFSR is ever all-zero, it SHALL reload SEED on the next edge.
REQ-026 Decision on a tick: mode=0 gives hit = (threshold > random), an unsigned WIDTH-bit compare using the pre-advance random; mode=1 gives hit = (threshold != 0).
REQ-027 move SHALL be registered: it is high in cycle N+1 exactly when a tick in cycle N had hit=1, and low otherwise; latency is 1 cycle.
REQ-028 move SHALL never be high on two consecutive cycles.
REQ-029 move SHALL never be high in IDLE or FREEZE, except for the single pulse owed to a tick taken in the cycle the state was left.
REQ-030 move_count SHALL increment when move=1 and saturate at 2^CW-1.
REQ-031 clear SHALL take priority over a simultaneous increment.
REQ-032 threshold=0 SHALL never produce a move in either mode.
REQ-033 In mode 0, threshold = all-ones SHALL produce a move on every tick unless random = all-ones.
REQ-034 A change to threshold or mode SHALL take effect on the next tick; there is no mid-period latching.
REQ-035 If enable drops in the tick cycle, the tick SHALL still complete: the LFSR advances and move pulses the next cycle.
REQ-036 clear in IDLE or RUN SHALL zero move_count, reload SEED and reset div to 0, with no state change.

Reset
REQ-037 While reset=0: state=IDLE, div=0, lfsr=SEED, move=0, move_count=0, busy=0.
REQ-038 These values SHALL hold asynchronously.
REQ-039 Reset asserted mid-RUN SHALL drop any pending move pulse.
REQ-040 The first tick after reset is released with enable=1 SHALL occur PERIOD cycles after entering RUN.

Verification (WIDTH=10, PERIOD=4, SEED=10'h001, CW=4)
REQ-041 reset low, then high with enable=1, mode=0, threshold=10'h3FF: the first three ticks see random 001, 002, 004; move pulses one cycle after each tick; move_count reaches 3.
REQ-042 threshold=10'h000, mode=1, 20 cycles in RUN: move stays 0; random still advances every 4 cycles.
REQ-043 threshold=10'h003, mode=0: the tick with random=001 gives a move; the ticks with random=002 and 004 give one move and no move respectively (3>2 is true, 3>4 is false).
REQ-044 mode=1 for 80 cycles: 20 moves; move_count saturates at 15 and holds; clear sets it to 0, and clear together with move also gives 0.
REQ-045 freeze pulse during RUN: busy falls next cycle, move stays 0, enable is ignored; clear returns to IDLE, then enable returns to RUN.
REQ-046 reset low for 1 cycle in the tick cycle: move does not pulse; random = 001 immediately.
